// File: rtl/mem_host_bridge_pkg.sv
// Shared definitions for the host command bridge: memory-port opcodes,
// register-space addresses, FSM encodings and the buffered command layout.
package mem_host_bridge_pkg;

  localparam logic [1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [1:0] MEM_OP_READ  = 2'd1;
  localparam logic [1:0] MEM_OP_WRITE = 2'd2;
  localparam logic [1:0] MEM_OP_RSVD  = 2'd3;

  localparam logic [63:0] MEM_ADDR_ICP_ENABLE = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MEM_ADDR_HALTED     = 64'h8000_0000_0000_0001;

  localparam int CMD_W = 130;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_RDREG  = 3'd2,
    ST_WAIT_P = 3'd3,
    ST_WAIT_D = 3'd4,
    ST_RESP   = 3'd5
  } bridge_state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
  } host_cmd_t;

  // A command is answered locally (never reaches the port) when it is not a
  // real access, targets an unknown register, writes the read-only HALTED
  // register, or touches memory while the ICP owns it.
  function automatic logic cmd_rejected(input logic [1:0]  op,
                                        input logic [63:0] addr,
                                        input logic        shadow_en);
    logic bad_op;
    logic bad_reg;
    logic ro_write;
    logic icp_owned;
    bad_op    = (op == MEM_OP_NOP) || (op == MEM_OP_RSVD);
    bad_reg   = addr[63] && (addr != MEM_ADDR_ICP_ENABLE) && (addr != MEM_ADDR_HALTED);
    ro_write  = (op == MEM_OP_WRITE) && (addr == MEM_ADDR_HALTED);
    icp_owned = !addr[63] && shadow_en;
    return bad_op || bad_reg || ro_write || icp_owned;
  endfunction

endpackage

// File: rtl/mem_host_bridge_cmd_fifo.sv
// Small synchronous command FIFO with wrap-bit pointers; storage is not reset,
// only the pointers are, so reset empties it.
module host_cmd_fifo
  import mem_host_bridge_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int WIDTH     = CMD_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(CMD_DEPTH);

  logic [WIDTH-1:0] mem_q [CMD_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mem_host_bridge.sv
// Host command bridge: buffers read/write commands and drives them one at a
// time onto the top-level memory/register port, returning one response each.
module mem_host_bridge
  import mem_host_bridge_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [63:0] i_cmd_addr,
  input  logic [63:0] i_cmd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic [1:0]  o_mem_op,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_data,
  input  logic [63:0] i_mem_data,
  input  logic        i_mem_op_pending,
  output logic        o_busy
);

  host_cmd_t     cmd_in;
  host_cmd_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  bridge_state_e state_q;
  logic          shadow_en_q;
  logic [1:0]    mem_op_q;
  logic [63:0]   mem_addr_q;
  logic [63:0]   mem_data_q;
  logic          rsp_valid_q;
  logic [63:0]   rsp_data_q;
  logic          rsp_err_q;
  logic          reject_d;

  assign cmd_in      = {i_cmd_op, i_cmd_addr, i_cmd_data};
  assign o_cmd_ready = !fifo_full;
  assign push        = i_cmd_valid && !fifo_full;
  assign pop         = (state_q == ST_IDLE) && !fifo_empty;

  host_cmd_fifo #(
    .CMD_DEPTH (CMD_DEPTH),
    .WIDTH     (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (cmd_in),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    reject_d = cmd_rejected(head.op, head.addr, shadow_en_q);
  end

  // Port op is a one-cycle pulse: every state except the IDLE issue path
  // falls back to NOP through the default assignment below.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      shadow_en_q <= 1'b0;
      mem_op_q    <= MEM_OP_NOP;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      mem_op_q <= MEM_OP_NOP;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (reject_d) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              state_q     <= ST_RESP;
            end else begin
              mem_op_q   <= head.op;
              mem_addr_q <= head.addr;
              mem_data_q <= head.data;
              state_q    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_op_q == MEM_OP_WRITE) begin
            if (mem_addr_q == MEM_ADDR_ICP_ENABLE) shadow_en_q <= mem_data_q[0];
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            state_q     <= ST_RESP;
          end else if (mem_addr_q[63]) begin
            state_q <= ST_RDREG;
          end else begin
            state_q <= ST_WAIT_P;
          end
        end
        ST_RDREG: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= i_mem_data;
          state_q     <= ST_RESP;
        end
        ST_WAIT_P: begin
          // The top never acknowledged the read: report it rather than hang.
          if (i_mem_op_pending) begin
            state_q <= ST_WAIT_D;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= ST_RESP;
          end
        end
        ST_WAIT_D: begin
          if (!i_mem_op_pending) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= i_mem_data;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mem_op    = mem_op_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: doc/mem_host_bridge.md
# mem_host_bridge

Host-side command bridge that sits directly upstream of the design top-level memory/register port. It accepts read/write commands on a valid/ready stream, buffers them in a small FIFO, and drives them one at a time onto the top-level `mem_op`/`mem_addr`/`mem_data` port, holding NOP otherwise. It tracks the read pending handshake and returns exactly one response (data + error flag) per command. It also keeps a shadow of the ICP-enable register so that memory accesses made while the ICP owns memory are rejected locally instead of being silently dropped.

## Interface
- `CMD_DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_cmd_valid`  in  1  command valid.
- `o_cmd_ready`  out  1  FIFO not full; combinational.
- `i_cmd_op`  in  2  0 NOP, 1 READ, 2 WRITE, 3 reserved.
- `i_cmd_addr`  in  64  bit 63 set = register space.
- `i_cmd_data`  in  64  write data.
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response accepted.
- `o_rsp_data`  out  64  read data; 0 for writes and errors.
- `o_rsp_err`  out  1  command rejected or not completed.
- `o_mem_op`  out  2  to top `i_mem_op`; registered.
- `o_mem_addr`  out  64  to top `i_mem_addr`; registered.
- `o_mem_data`  out  64  to top `i_mem_data`; registered.
- `i_mem_data`  in  64  from top `o_mem_data`.
- `i_mem_op_pending`  in  1  from top `o_mem_op_pending`.
- `o_busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Push when `i_cmd_valid & o_cmd_ready`. When full, ready is 0 even if a pop happens in the same cycle.
- FSM states:
  - IDLE: wait for FIFO non-empty. Pop one command and classify it:
    - op NOP or 3 → RESP with err=1; not issued.
    - register address other than 0x8000_0000_0000_0000 (ICP_ENABLE) or 0x8000_0000_0000_0001 (HALTED) → RESP with err=1.
    - write to HALTED → RESP with err=1.
    - memory address (bit 63 = 0) while shadow_en=1 → RESP with err=1.
    - otherwise load the `o_mem_*` registers and go to ISSUE.
  - ISSUE: command is on the port for exactly one cycle. Next state:
    - write → RESP, err=0, data 0. A write to ICP_ENABLE sets shadow_en <= data[0].
    - register read → RDREG.
    - memory read → WAIT_P.
  - RDREG: capture `i_mem_data` → RESP.
  - WAIT_P: if pending=1 → WAIT_D; else → RESP with err=1, data 0.
  - WAIT_D: when pending=0, capture `i_mem_data` → RESP.
  - RESP: `o_rsp_valid`=1; on `i_rsp_ready` → IDLE.
- `o_mem_op` returns to NOP on the cycle after ISSUE and stays NOP in every other state. Address and data may hold their last values.
- Reset (asynchronous, any state, including mid-read): FIFO emptied, FSM to IDLE, shadow_en=0, any in-flight response discarded.
- Output values during and after reset:
  - `o_mem_op`=0, `o_mem_addr`=0, `o_mem_data`=0.
  - `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_err`=0.
  - `o_busy`=0, `o_cmd_ready`=1.

## Timing
- Command popped in cycle A; ISSUE at A+1. Local rejects show `o_rsp_valid` at A+1.
- First response-valid cycle:
  - writes: A+2.
  - register reads: A+3.
  - memory reads: A+5 (pending high at A+2 and A+3, data captured at A+4).
- At most one command in flight; the next pop occurs in the IDLE cycle after the RESP handshake.
- Response fields are stable while `o_rsp_valid`=1 and `i_rsp_ready`=0.

## Structure
- Shared package holds:
  - MEM_OP_NOP/READ/WRITE.
  - MEM_ADDR_ICP_ENABLE, MEM_ADDR_HALTED.
  - FSM state encodings.
- Sub-module `host_cmd_fifo`: synchronous FIFO of width 130 (op, addr, data), parameter CMD_DEPTH, with full/empty flags and the same asynchronous reset.

## Test plan
- Memory write 0x10 ← 0xDEAD_BEEF, then read 0x10:
  - read response err=0, data 0xDEAD_BEEF.
  - first response-valid cycle is 5 cycles after the pop.
  - `o_mem_op`=READ for exactly one cycle.
- Write ICP_ENABLE ← 1, then read memory 0x0:
  - read response err=1, data 0.
  - `o_mem_op` stays NOP throughout.
  - read ICP_ENABLE returns 1, err=0.
- Read HALTED with the ICP stopped → err=0, data in {0,1} matching the top-level halted flag, response 3 cycles after the pop. Read 0x8000_0000_0000_0002 → err=1.
- Push 6 commands back-to-back with `i_rsp_ready`=0:
  - `o_cmd_ready` drops after CMD_DEPTH+1 accepted.
  - responses emerge in order once ready rises.
- Assert `i_rst` during WAIT_D:
  - all outputs at their reset values immediately.
  - no response emitted.
  - shadow_en=0.
- Memory read with pending forced low at WAIT_P → err=1 at the expected cycle, data 0.
